wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two buffered producers (ALU, LSU) merged round-robin onto one register-file write port.
// Optional macro WB_ZERO_GUARD_EN: writes to register 0 are accepted but dropped, and PEND_MASK[0] is held at 0.
module wb_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ALU_VALID,
   output logic        ALU_READY,
   input  logic [4:0]  ALU_WADDR,
   input  logic [31:0] ALU_WDATA,
   input  logic        LSU_VALID,
   output logic        LSU_READY,
   input  logic [4:0]  LSU_WADDR,
   input  logic [31:0] LSU_WDATA,
   output logic        WE,
   output logic [4:0]  WADDR,
   output logic [31:0] WDATA,
   output logic [31:0] PEND_MASK
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {GNT_ALU, GNT_LSU} grant_e;

   // Source index 0 is the ALU, 1 is the LSU.
   logic [4:0]    addr_q [2][DEPTH];
   logic [31:0]   data_q [2][DEPTH];
   logic [PW-1:0] wr_q [2];
   logic [PW-1:0] rd_q [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [4:0]    in_addr [2];
   logic [31:0]   in_data [2];
   logic [1:0]    in_valid, ready, push, pop, nonempty;
   logic          sel;
   grant_e        last_q, last_d;
   logic          we_q;
   logic [4:0]    waddr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   pend;

   assign in_valid   = {LSU_VALID, ALU_VALID};
   assign in_addr[0] = ALU_WADDR;
   assign in_addr[1] = LSU_WADDR;
   assign in_data[0] = ALU_WDATA;
   assign in_data[1] = LSU_WDATA;
   assign sel        = pop[1];

   always_comb begin
      pop    = '0;
      last_d = last_q;
      for (int unsigned s = 0; s < 2; s++) begin
         ready[s]    = (cnt_q[s] < CW'(DEPTH));
         nonempty[s] = (cnt_q[s] != '0);
         push[s]     = in_valid[s] && ready[s];
`ifdef WB_ZERO_GUARD_EN
         if (in_addr[s] == '0) push[s] = 1'b0;
`endif
      end
      // The grant flag only moves when both sources contend.
      if (&nonempty) begin
         if (last_q == GNT_LSU) begin
            pop[0] = 1'b1;
            last_d = GNT_ALU;
         end else begin
            pop[1] = 1'b1;
            last_d = GNT_LSU;
         end
      end else begin
         pop = nonempty;
      end
      for (int unsigned s = 0; s < 2; s++) begin
         cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned s = 0; s < 2; s++) begin
            wr_q[s]  <= '0;
            rd_q[s]  <= '0;
            cnt_q[s] <= '0;
         end
         last_q  <= GNT_LSU;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         for (int unsigned s = 0; s < 2; s++) begin
            if (push[s]) begin
               addr_q[s][wr_q[s]] <= in_addr[s];
               data_q[s][wr_q[s]] <= in_data[s];
               wr_q[s]            <= wr_q[s] + 1'b1;
            end
            if (pop[s]) rd_q[s] <= rd_q[s] + 1'b1;
            cnt_q[s] <= cnt_d[s];
         end
         last_q <= last_d;
         we_q   <= |pop;
         if (|pop) begin
            waddr_q <= addr_q[sel][rd_q[sel]];
            wdata_q <= data_q[sel][rd_q[sel]];
         end
      end
   end

   always_comb begin
      logic [PW-1:0] off;
      off  = '0;
      pend = '0;
      for (int unsigned s = 0; s < 2; s++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            // Slot i is live when its distance from the read pointer is below the count.
            off = PW'(i) - rd_q[s];
            if ({1'b0, off} < cnt_q[s]) pend[addr_q[s][i]] = 1'b1;
         end
      end
      if (we_q) pend[waddr_q] = 1'b1;
`ifdef WB_ZERO_GUARD_EN
      pend[0] = 1'b0;
`endif
   end

   assign ALU_READY = ready[0];
   assign LSU_READY = ready[1];
   assign WE        = we_q;
   assign WADDR     = waddr_q;
   assign WDATA     = wdata_q;
   assign PEND_MASK = pend;

endmodule
